// File: rtl/gray_seq_counter_pkg.sv
// -----------------------------------------------------------------------------
// gray_seq_counter_pkg
// Shared definitions for the Gray-code sequence counter.
//   DEFAULT_WIDTH : default code width (bits) of the counter and its ports
//   state_t       : sequencer state encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package gray_seq_counter_pkg;

  // Default code width used by the counter when WIDTH is not overridden.
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Sequencer states. The encodings are fixed so that debug tooling and
  // downstream logs can decode the state value directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : gray_seq_counter_pkg

// File: rtl/gray_seq_counter_bin_to_gray.sv
// -----------------------------------------------------------------------------
// bin_to_gray
// Purely combinational binary-to-reflected-Gray converter.
//   WIDTH : code width in bits
// Ports:
//   bin  (in,  WIDTH) : binary value
//   gray (out, WIDTH) : reflected Gray code of bin, zero latency
// -----------------------------------------------------------------------------
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of the matching binary bit and its upper neighbour;
  // the MSB passes straight through because the shift feeds in a zero.
  assign gray = bin ^ (bin >> 1);

endmodule : bin_to_gray

// File: rtl/gray_seq_counter.sv
// -----------------------------------------------------------------------------
// gray_seq_counter
// Loadable up/down counter that steps through a run of Gray codes until a
// Gray-coded limit is reached. The count is held in binary and presented as
// Gray so successive outputs always differ in exactly one bit, wrap included.
//
// Parameters:
//   WIDTH  : code width in bits
// Ports:
//   clk    (in)        : clock, all state changes on the rising edge
//   resetn (in)        : asynchronous active-low reset
//   load   (in)        : load ld_val into the counter (IDLE only)
//   ld_val (in, WIDTH) : Gray-coded load value
//   start  (in)        : begin a stepping sequence (IDLE only, load wins)
//   abort  (in)        : end the sequence without done (RUN only)
//   en     (in)        : step enable while in RUN
//   up     (in)        : direction, 1 = increment, 0 = decrement
//   lim    (in, WIDTH) : Gray-coded terminal value
//   g      (out,WIDTH) : current Gray code, combinational from the counter
//   busy   (out)       : high while in RUN
//   done   (out)       : one-cycle pulse when lim has been reached
//   tc     (out)       : one-cycle pulse after a wrapping step
// -----------------------------------------------------------------------------
module gray_seq_counter
  import gray_seq_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] g,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             tc_r;

  logic [WIDTH-1:0] ld_bin_s;
  logic [WIDTH-1:0] step_s;
  logic             wrap_s;
  logic             at_lim_s;

  // Gray view of the binary counter; this is the g output itself.
  bin_to_gray #(
    .WIDTH (WIDTH)
  ) u_bin_to_gray (
    .bin  (cnt_r),
    .gray (g)
  );

  // Gray-to-binary of the load value: binary bit i is the XOR of all Gray
  // bits from i up to the MSB (prefix XOR starting at the MSB).
  always_comb begin
    ld_bin_s = CNT_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      ld_bin_s[i] = ^(ld_val >> i);
    end
  end

  // Next count for an enabled step and whether that step crosses the wrap
  // point (all-ones -> zero going up, zero -> all-ones going down).
  always_comb begin
    if (up) begin
      step_s = cnt_r + CNT_ONE;
      wrap_s = &cnt_r;
    end else begin
      step_s = cnt_r - CNT_ONE;
      wrap_s = ~|cnt_r;
    end
  end

  // Limit detection is done on the Gray value so lim needs no conversion.
  always_comb begin
    if (g == lim) begin
      at_lim_s = 1'b1;
    end else begin
      at_lim_s = 1'b0;
    end
  end

  // Sequencer FSM with the counter and all status outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      // done and tc are single-cycle pulses; they are only raised below.
      done_r <= 1'b0;
      tc_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          // load outranks start: a combined request only loads.
          if (load) begin
            cnt_r   <= ld_bin_s;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          // Priority: abort, then limit reached, then stepping.
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (at_lim_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (en) begin
            cnt_r   <= step_s;
            tc_r    <= wrap_s;
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign tc   = tc_r;

endmodule : gray_seq_counter

// File: tb/tb_gray_seq_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_seq_counter
// Self-checking bench for gray_seq_counter: directed scenarios plus a
// randomized run, all compared against an integer-valued reference model.
// -----------------------------------------------------------------------------
module tb_gray_seq_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         resetn;
  logic         load;
  logic [W-1:0] ld_val;
  logic         start;
  logic         abort;
  logic         en;
  logic         up;
  logic [W-1:0] lim;
  logic [W-1:0] g;
  logic         busy;
  logic         done;
  logic         tc;

  int n_checks;
  int n_fail;

  // Reference model: count as an integer, phase 0 = idle, 1 = run, 2 = done.
  int m_cnt;
  int m_phase;
  int m_tc;

  gray_seq_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .load   (load),
    .ld_val (ld_val),
    .start  (start),
    .abort  (abort),
    .en     (en),
    .up     (up),
    .lim    (lim),
    .g      (g),
    .busy   (busy),
    .done   (done),
    .tc     (tc)
  );

  // 10-unit clock, first rising edge at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  // Binary value of a Gray code found by searching the code table.
  function automatic int bin_of_gray(input int gv);
    for (int k = 0; k < MOD; k++) begin
      if (gray_of(k) == gv) return k;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_tc    = 0;
  endfunction

  // One rising edge of the reference model, using the inputs now applied.
  function automatic void model_step();
    m_tc = 0;
    case (m_phase)
      0: begin
        if (load) m_cnt = bin_of_gray(int'(ld_val));
        else if (start) m_phase = 1;
      end
      1: begin
        if (abort) m_phase = 0;
        else if (gray_of(m_cnt) == int'(lim)) m_phase = 2;
        else if (en) begin
          if (up) begin
            if (m_cnt == MOD - 1) m_tc = 1;
            m_cnt = (m_cnt + 1) % MOD;
          end else begin
            if (m_cnt == 0) m_tc = 1;
            m_cnt = (m_cnt + MOD - 1) % MOD;
          end
        end
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic check_model(input string tag);
    check_eq({tag, ".g"},    32'(g),    32'(gray_of(m_cnt)));
    check_eq({tag, ".busy"}, 32'(busy), 32'(m_phase == 1));
    check_eq({tag, ".done"}, 32'(done), 32'(m_phase == 2));
    check_eq({tag, ".tc"},   32'(tc),   32'(m_tc));
  endtask

  // Advance one clock: model updates on the rising edge, outputs checked on
  // the following falling edge, where new inputs may then be applied.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; ld_val = v; start = 1'b0;
    tick("load");
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick("start");
    start = 1'b0;
  endtask

  int steps;
  int done_cnt;
  int tc_cnt;
  logic [W-1:0] prev_g;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn = 1'b0; load = 1'b0; ld_val = '0; start = 1'b0; abort = 1'b0;
    en = 1'b0; up = 1'b1; lim = '0;
    model_reset();
    @(negedge clk);
    check_model("reset");
    resetn = 1'b1;
    tick("post_reset");

    // Load 1100, lim 1101, step up once, done two cycles after start.
    en = 1'b1; up = 1'b1; lim = 4'b1101;
    do_load(4'b1100);
    check_eq("ld1100.g", 32'(g), 32'(4'b1100));
    do_start();
    check_eq("r38.run_g", 32'(g), 32'(4'b1100));
    check_eq("r38.busy", 32'(busy), 32'(1'b1));
    tick("r38a");
    check_eq("r38.step_g", 32'(g), 32'(4'b1101));
    tick("r38b");
    check_eq("r38.done", 32'(done), 32'(1'b1));
    tick("r38c");
    check_eq("r38.done_off", 32'(done), 32'(1'b0));

    // Full sweep 0000..1000: 15 single-bit steps, one done, no tc.
    lim = 4'b1000; up = 1'b1; en = 1'b1;
    do_load(4'b0000);
    do_start();
    steps = 0; done_cnt = 0; tc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      prev_g = g;
      tick("r39");
      if (g != prev_g) begin
        steps++;
        check_eq("r39.onebit", 32'($countones(g ^ prev_g)), 32'd1);
      end
      if (done) done_cnt++;
      if (tc) tc_cnt++;
    end
    check_eq("r39.steps", 32'(steps), 32'd15);
    check_eq("r39.done_cnt", 32'(done_cnt), 32'd1);
    check_eq("r39.tc_cnt", 32'(tc_cnt), 32'd0);
    check_eq("r39.final_g", 32'(g), 32'(4'b1000));

    // Wrap going up: 1000 -> 0000 (tc) -> 0001 -> done.
    lim = 4'b0001; up = 1'b1;
    do_load(4'b1000);
    do_start();
    tick("wrap_up0");
    check_eq("wrap_up.g0", 32'(g), 32'(4'b0000));
    check_eq("wrap_up.tc", 32'(tc), 32'(1'b1));
    tick("wrap_up1");
    check_eq("wrap_up.g1", 32'(g), 32'(4'b0001));
    tick("wrap_up2");
    check_eq("wrap_up.done", 32'(done), 32'(1'b1));
    tick("wrap_up3");

    // Wrap going down: 0000 -> 1000 (tc) -> 1001 -> done.
    lim = 4'b1001; up = 1'b0;
    do_load(4'b0000);
    do_start();
    tick("wrap_dn0");
    check_eq("wrap_dn.g0", 32'(g), 32'(4'b1000));
    check_eq("wrap_dn.tc", 32'(tc), 32'(1'b1));
    tick("wrap_dn1");
    check_eq("wrap_dn.g1", 32'(g), 32'(4'b1001));
    tick("wrap_dn2");
    check_eq("wrap_dn.done", 32'(done), 32'(1'b1));
    tick("wrap_dn3");

    // Start already at the limit: one RUN cycle, then DONE, no steps.
    lim = 4'b0101; up = 1'b1; en = 1'b1;
    do_load(4'b0101);
    do_start();
    tick("atlim");
    check_eq("atlim.done", 32'(done), 32'(1'b1));
    check_eq("atlim.g", 32'(g), 32'(4'b0101));
    tick("atlim2");

    // en toggling holds the count; abort returns to IDLE without done.
    lim = 4'b1111; up = 1'b1; en = 1'b1;
    do_load(4'b0000);
    do_start();
    tick("en1");
    check_eq("en1.g", 32'(g), 32'(4'b0001));
    en = 1'b0;
    tick("en0");
    check_eq("en0.hold", 32'(g), 32'(4'b0001));
    en = 1'b1;
    tick("en1b");
    check_eq("en1b.g", 32'(g), 32'(4'b0011));
    abort = 1'b1;
    tick("abort");
    abort = 1'b0;
    check_eq("abort.busy", 32'(busy), 32'(1'b0));
    check_eq("abort.g", 32'(g), 32'(4'b0011));
    check_eq("abort.done", 32'(done), 32'(1'b0));
    tick("abort2");
    check_eq("abort2.done", 32'(done), 32'(1'b0));

    // Simultaneous load and start: load only, stay IDLE.
    load = 1'b1; ld_val = 4'b0110; start = 1'b1;
    tick("ldst");
    idle_inputs();
    check_eq("ldst.g", 32'(g), 32'(4'b0110));
    check_eq("ldst.busy", 32'(busy), 32'(1'b0));
    tick("ldst2");
    check_eq("ldst2.busy", 32'(busy), 32'(1'b0));

    // Asynchronous reset in the middle of a RUN, between clock edges.
    lim = 4'b1000; up = 1'b1; en = 1'b1;
    do_load(4'b0000);
    do_start();
    tick("prerst0");
    tick("prerst1");
    #1 resetn = 1'b0;
    model_reset();
    #1;
    check_eq("arst.g", 32'(g), 32'(4'b0000));
    check_eq("arst.busy", 32'(busy), 32'(1'b0));
    check_eq("arst.done", 32'(done), 32'(1'b0));
    #1 resetn = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick("postrst");
      if (done) done_cnt++;
    end
    check_eq("postrst.no_done", 32'(done_cnt), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      load   = ($urandom_range(0, 9) == 0);
      ld_val = W'($urandom_range(0, MOD - 1));
      start  = ($urandom_range(0, 4) == 0);
      abort  = ($urandom_range(0, 19) == 0);
      en     = ($urandom_range(0, 9) < 7);
      up     = 1'($urandom_range(0, 1));
      lim    = W'($urandom_range(0, MOD - 1));
      tick("rand");
    end
    idle_inputs();
    tick("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gray_seq_counter

// File: doc/gray_seq_counter.md
GRAY_SEQ_COUNTER -- requirements
Module: gray_seq_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the code width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port resetn, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have port load, input, 1, which loads ld_val into the counter (honoured only in IDLE).
REQ-005 SHALL have port ld_val, input, WIDTH, the Gray-coded load value.
REQ-006 SHALL have port start, input, 1, a start-sequence pulse (honoured only in IDLE).
REQ-007 SHALL have port abort, input, 1, which terminates a sequence (honoured only in RUN).
REQ-008 SHALL have port en, input, 1, the step enable while in RUN.
REQ-009 SHALL have port up, input, 1, the direction: 1 increments, 0 decrements.
REQ-010 SHALL have port lim, input, WIDTH, the Gray-coded terminal value.
REQ-011 SHALL have port g, output, WIDTH, the current Gray code; it feeds the downstream Gray-to-binary stage.
REQ-012 SHALL have port busy, output, 1, asserted high while the state is RUN.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse when lim is reached.
REQ-014 SHALL have port tc, output, 1, a one-cycle wrap pulse.

Function
REQ-015 SHALL hold an internal binary register cnt[WIDTH-1:0].
REQ-016 SHALL drive g = cnt ^ (cnt >> 1) combinationally from the register, with zero added latency.
REQ-017 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-018 In IDLE: load=1 SHALL set cnt to the binary equivalent of ld_val (prefix-XOR from the MSB) on the next edge.
REQ-019 In IDLE: start=1 with load=0 SHALL move the state to RUN on the next edge.
REQ-020 In IDLE: load and start asserted together SHALL apply the load, ignore start, and keep the state IDLE.
REQ-021 In RUN, when g==lim, SHALL move to DONE without stepping; this check takes priority over en.
REQ-022 In RUN with g!=lim and en=1, SHALL step cnt by +1 or -1 per up, modulo 2^WIDTH.
REQ-023 In RUN with en=0, SHALL hold cnt and remain in RUN.
REQ-024 In RUN, abort=1 SHALL force the next state to IDLE and hold cnt; abort outranks the limit check, and no done is produced.
REQ-025 In RUN, load and start SHALL be ignored.
REQ-026 DONE SHALL last exactly one cycle, with done=1, then return to IDLE; cnt holds.
REQ-027 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-028 tc SHALL be a registered pulse, high for the one cycle after a step from all-ones to zero (up) or zero to all-ones (down).
REQ-029 Successive g values during stepping SHALL differ in exactly one bit, including across wrap.
REQ-030 Starting with g==lim SHALL give RUN for 1 cycle, then DONE, with zero steps.
REQ-031 lim, up and en SHALL be sampled every cycle; changes take effect on the next edge.

Reset
REQ-032 resetn low SHALL immediately, without a clock edge, force cnt=0, g=0, state=IDLE, busy=0, done=0, tc=0.
REQ-033 Reset asserted mid-RUN SHALL abandon the sequence and produce no done.
REQ-034 After resetn deasserts, the first honoured input SHALL be sampled on the next rising edge.

Structure
REQ-035 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL live in a shared package/header.
REQ-036 Binary-to-Gray conversion SHALL be one sub-module, bin_to_gray (WIDTH-parameterised, combinational), instanced for g.
REQ-037 The Gray-to-binary load conversion SHALL be inline in the block.

Verification
REQ-038 Load 1100, lim=1101, up=1, en=1, start -> g 1100 then 1101; done pulses 2 cycles after start; tc=0.
REQ-039 Load 0000, lim=1000, up=1, start -> 16 one-bit-change values 0000..1000, 15 steps, single done, tc never set.
REQ-040 Wrap cases:
- Load 1000, lim=0001, up=1 -> g 1000, 0000 (tc=1 that cycle), 0001, then done.
- Load 0000, lim=1001, up=0 -> 0000, 1000 (tc), 1001, then done.
REQ-041 In RUN, toggle en 1,0,1 -> g holds during the en=0 cycle; then abort -> IDLE next edge, g held, busy=0, no done.
REQ-042 Simultaneous load=1, ld_val=0110, start=1 in IDLE -> g=0110, state stays IDLE, busy=0.
REQ-043 resetn low mid-RUN between edges -> g=0000, busy=0 immediately; no done after release.
